// File: rtl/rv32i_lsu_byteseq.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_lsu_byteseq
// Purpose  : Splits one RV32I load/store into 1, 2 or 4 little-endian byte
//            accesses on a byte-wide RAM with registered read data, and
//            reassembles and extends load results to 32 bits.
// Option   : RV32I_LSU_MISALIGN_TRAP_EN - when defined, misaligned LH/LHU/SH
//            and LW/SW are reported as errors with no memory access.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_lsu_byteseq #(
  parameter int AWIDTH = 12
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic              o_resp_err,
  output logic [31:0]       o_resp_rdata,
  output logic [7:0]        o_mem_data,
  output logic              o_mem_wren,
  output logic [AWIDTH-1:0] o_mem_address,
  input  logic [7:0]        i_mem_q
);

  // S_RESP is only ever a next-state value: the edge that raises resp_valid
  // already lands in S_IDLE, so req_ready is high during the resp cycle.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_LOAD  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  // r_cnt equals j during the cycle that ends at edge Ej of a transaction
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_next;
  logic [2:0]          r_n;
  logic                r_uns;
  logic [AWIDTH-1:0]   r_base;
  logic [31:0]         r_wdata;
  logic [23:0]         r_lanes;
  logic [23:0]         w_lanes_next;

  logic [7:0]          r_mem_data;
  logic                r_mem_wren;
  logic [AWIDTH-1:0]   r_mem_address;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [31:0]         r_resp_rdata;

  logic [7:0]          w_mem_data_next;
  logic                w_mem_wren_next;
  logic [AWIDTH-1:0]   w_mem_address_next;
  logic                w_resp_valid_next;
  logic                w_resp_err_next;
  logic [31:0]         w_resp_rdata_next;

  logic                w_accept;
  logic [2:0]          w_req_n;
  logic                w_req_uns;
  logic                w_req_misalign;
  logic                w_req_err;
  logic [AWIDTH-1:0]   w_issue_addr;
  logic [7:0]          w_issue_byte;
  logic [1:0]          w_cap_idx;
  logic [31:0]         w_load_result;
  logic                w_unused;

  assign o_req_ready   = (r_state == S_IDLE) && !i_reset;
  assign w_accept      = i_req_valid && o_req_ready;

  assign o_mem_data    = r_mem_data;
  assign o_mem_wren    = r_mem_wren;
  assign o_mem_address = r_mem_address;
  assign o_resp_valid  = r_resp_valid;
  assign o_resp_err    = r_resp_err;
  assign o_resp_rdata  = r_resp_rdata;

  // Upper address bits are outside the RAM and intentionally ignored
  assign w_unused = ^i_req_addr[31:AWIDTH];

  // Size/sign decode; n==0 marks an illegal funct3 for the given direction
  always_comb begin
    w_req_n   = 3'd0;
    w_req_uns = 1'b0;
    case (i_req_funct3)
      3'b000:  w_req_n = 3'd1;
      3'b001:  w_req_n = 3'd2;
      3'b010:  w_req_n = 3'd4;
      3'b100:  begin
        w_req_n   = i_req_we ? 3'd0 : 3'd1;
        w_req_uns = 1'b1;
      end
      3'b101:  begin
        w_req_n   = i_req_we ? 3'd0 : 3'd2;
        w_req_uns = 1'b1;
      end
      default: w_req_n = 3'd0;
    endcase
  end

`ifdef RV32I_LSU_MISALIGN_TRAP_EN
  assign w_req_misalign = ((w_req_n == 3'd2) && i_req_addr[0]) ||
                          ((w_req_n == 3'd4) && (i_req_addr[1:0] != 2'b00));
`else
  assign w_req_misalign = 1'b0;
`endif

  assign w_req_err    = (w_req_n == 3'd0) || w_req_misalign;

  // Byte k lives at base+k, wrapping naturally at the RAM size
  assign w_issue_addr = r_base + AWIDTH'(r_cnt);
  assign w_cap_idx    = r_cnt[1:0] - 2'd2;

  // Pick store byte lane r_cnt from the latched write data
  always_comb begin
    case (r_cnt[1:0])
      2'd0:    w_issue_byte = r_wdata[7:0];
      2'd1:    w_issue_byte = r_wdata[15:8];
      2'd2:    w_issue_byte = r_wdata[23:16];
      default: w_issue_byte = r_wdata[31:24];
    endcase
  end

  // Final capture: mem_q is the top byte, earlier bytes come from the lanes
  always_comb begin
    case (r_n)
      3'd1:    w_load_result = r_uns ? {24'h0, i_mem_q}
                                     : {{24{i_mem_q[7]}}, i_mem_q};
      3'd2:    w_load_result = r_uns ? {16'h0, i_mem_q, r_lanes[7:0]}
                                     : {{16{i_mem_q[7]}}, i_mem_q, r_lanes[7:0]};
      default: w_load_result = {i_mem_q, r_lanes[23:0]};
    endcase
  end

  // Next-state and next-output logic for the sequencer
  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_lanes_next       = r_lanes;
    w_mem_wren_next    = 1'b0;
    w_mem_data_next    = 8'h00;
    w_mem_address_next = r_mem_address;
    w_resp_valid_next  = 1'b0;
    w_resp_err_next    = 1'b0;
    w_resp_rdata_next  = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_state_next      = S_RESP;
            w_resp_valid_next = 1'b1;
            w_resp_err_next   = 1'b1;
          end else begin
            w_cnt_next         = 3'd1;
            w_mem_address_next = i_req_addr[AWIDTH-1:0];
            if (i_req_we) begin
              w_state_next    = S_STORE;
              w_mem_wren_next = 1'b1;
              w_mem_data_next = i_req_wdata[7:0];
            end else begin
              w_state_next    = S_LOAD;
            end
          end
        end
      end
      S_STORE: begin
        if (r_cnt == r_n) begin
          w_state_next      = S_RESP;
          w_resp_valid_next = 1'b1;
        end else begin
          w_mem_wren_next    = 1'b1;
          w_mem_address_next = w_issue_addr;
          w_mem_data_next    = w_issue_byte;
          w_cnt_next         = r_cnt + 3'd1;
        end
      end
      S_LOAD: begin
        // Issue of byte r_cnt overlaps with capture of byte r_cnt-2
        if (r_cnt < r_n) begin
          w_mem_address_next = w_issue_addr;
        end
        if (r_cnt == (r_n + 3'd1)) begin
          w_state_next      = S_RESP;
          w_resp_valid_next = 1'b1;
          w_resp_rdata_next = w_load_result;
        end else begin
          w_cnt_next = r_cnt + 3'd1;
          if (r_cnt >= 3'd2) begin
            case (w_cap_idx)
              2'd0:    w_lanes_next[7:0]   = i_mem_q;
              2'd1:    w_lanes_next[15:8]  = i_mem_q;
              default: w_lanes_next[23:16] = i_mem_q;
            endcase
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 3'd0;
      r_n           <= 3'd0;
      r_uns         <= 1'b0;
      r_base        <= '0;
      r_wdata       <= 32'h0;
      r_lanes       <= 24'h0;
      r_mem_data    <= 8'h00;
      r_mem_wren    <= 1'b0;
      r_mem_address <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= 32'h0;
    end else begin
      r_state       <= (w_state_next == S_RESP) ? S_IDLE : w_state_next;
      r_cnt         <= w_cnt_next;
      r_lanes       <= w_lanes_next;
      r_mem_data    <= w_mem_data_next;
      r_mem_wren    <= w_mem_wren_next;
      r_mem_address <= w_mem_address_next;
      r_resp_valid  <= w_resp_valid_next;
      r_resp_err    <= w_resp_err_next;
      r_resp_rdata  <= w_resp_rdata_next;
      if (w_accept) begin
        r_n     <= w_req_n;
        r_uns   <= w_req_uns;
        r_base  <= i_req_addr[AWIDTH-1:0];
        r_wdata <= i_req_wdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_lsu_byteseq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_lsu_byteseq
// Purpose  : Self-checking bench for rv32i_lsu_byteseq with a byte RAM model,
//            a per-cycle expectation table built from request semantics, and
//            directed literal checks plus randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_lsu_byteseq;

  localparam int AW   = 12;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_we;
  logic [2:0]    i_req_funct3;
  logic [31:0]   i_req_addr;
  logic [31:0]   i_req_wdata;
  logic          o_resp_valid;
  logic          o_resp_err;
  logic [31:0]   o_resp_rdata;
  logic [7:0]    o_mem_data;
  logic          o_mem_wren;
  logic [AW-1:0] o_mem_address;
  logic [7:0]    ram_q;

  rv32i_lsu_byteseq #(.AWIDTH(AW)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_resp_valid (o_resp_valid),
    .o_resp_err   (o_resp_err),
    .o_resp_rdata (o_resp_rdata),
    .o_mem_data   (o_mem_data),
    .o_mem_wren   (o_mem_wren),
    .o_mem_address(o_mem_address),
    .i_mem_q      (ram_q)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; cycle c is the one started by edge c
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM with registered (read-old) output
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (o_mem_wren) ram[o_mem_address] <= o_mem_data;
    ram_q <= ram[o_mem_address];
  end

  // Reference memory contents as the requests say they should be
  bit [7:0]  shadow   [0:4095];

  // Expected per-cycle behaviour
  bit        exp_busy [MAXC];
  bit        exp_wren [MAXC];
  bit [7:0]  exp_data [MAXC];
  bit        exp_aset [MAXC];
  bit [11:0] exp_addr [MAXC];
  bit        exp_rv   [MAXC];
  bit        exp_err  [MAXC];
  bit [31:0] exp_rdata[MAXC];

  int        n_tests = 0;
  int        n_fail  = 0;
  bit        chk_on  = 1'b0;
  bit [11:0] model_addr = 12'h000;
  int        last_resp_cyc = -100;
  bit [31:0] last_rdata = 32'h0;
  bit        last_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, expv);
    end
  endtask

  // Per-cycle comparison of every DUT output against the expectation table
  always @(negedge clk) begin
    if (chk_on && cyc < MAXC) begin
      if (exp_aset[cyc]) model_addr = exp_addr[cyc];
      chk("ready", 32'(o_req_ready), 32'(!exp_busy[cyc] && !rst));
      chk("wren",  32'(o_mem_wren),  32'(exp_wren[cyc]));
      chk("data",  32'(o_mem_data),  32'(exp_data[cyc]));
      chk("addr",  32'(o_mem_address), 32'(model_addr));
      chk("rvalid", 32'(o_resp_valid), 32'(exp_rv[cyc]));
      if (exp_rv[cyc]) begin
        chk("rerr",  32'(o_resp_err), 32'(exp_err[cyc]));
        chk("rdata", o_resp_rdata, exp_rdata[cyc]);
      end
      if (o_resp_valid === 1'b1) begin
        last_resp_cyc = cyc;
        last_rdata    = o_resp_rdata;
        last_err      = o_resp_err;
      end
    end
  end

  // Record what a request accepted at edge c0 must do, from the ISA rules
  task automatic model_fill(input bit we, input bit [2:0] f3, input bit [31:0] a,
                            input bit [31:0] wd, input int c0, output int rc);
    int        n;
    bit        sgn;
    bit        legal;
    bit [11:0] ak;
    bit [31:0] v;
    n = 0; sgn = 1'b0;
    case (f3)
      3'd0: begin n = 1; sgn = 1'b1; end
      3'd1: begin n = 2; sgn = 1'b1; end
      3'd2: n = 4;
      3'd4: n = we ? 0 : 1;
      3'd5: n = we ? 0 : 2;
      default: n = 0;
    endcase
    legal = (n != 0);
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    if (n == 2 && a[0]) legal = 1'b0;
    if (n == 4 && a[1:0] != 2'b00) legal = 1'b0;
`endif
    rc = c0;
    if (c0 + 6 >= MAXC) return;
    if (!legal) begin
      exp_rv[c0] = 1'b1; exp_err[c0] = 1'b1; exp_rdata[c0] = 32'h0;
      return;
    end
    v = 32'h0;
    for (int k = 0; k < n; k++) begin
      ak = a[11:0] + 12'(k);
      exp_busy[c0+k] = 1'b1;
      exp_aset[c0+k] = 1'b1;
      exp_addr[c0+k] = ak;
      if (we) begin
        exp_wren[c0+k] = 1'b1;
        exp_data[c0+k] = wd[8*k +: 8];
        shadow[ak]     = wd[8*k +: 8];
      end else begin
        v = v | (32'(shadow[ak]) << (8*k));
      end
    end
    if (we) begin
      rc = c0 + n;
    end else begin
      exp_busy[c0+n] = 1'b1;
      if (sgn && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (sgn && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      rc = c0 + n + 1;
    end
    exp_rv[rc] = 1'b1; exp_err[rc] = 1'b0; exp_rdata[rc] = v;
  endtask

  task automatic junk_req(input bit valid);
    i_req_valid  = valid;
    i_req_we     = 1'($urandom_range(0, 1));
    i_req_funct3 = 3'($urandom_range(0, 7));
    i_req_addr   = $urandom;
    i_req_wdata  = $urandom;
  endtask

  // Present a request (called just after a falling edge) and wait for acceptance
  task automatic accept(input bit we, input bit [2:0] f3, input bit [31:0] a,
                        input bit [31:0] wd, output int c0, output int rc);
    int w;
    w = 0; c0 = -1; rc = -1;
    while (!o_req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!o_req_ready) begin
      chk("ready_timeout", 32'(o_req_ready), 32'd1);
      return;
    end
    i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3;
    i_req_addr = a; i_req_wdata = wd;
    @(posedge clk);
    c0 = cyc + 1;
    model_fill(we, f3, a, wd, c0, rc);
    #1;
    junk_req(1'b0);
  endtask

  // Wait to the falling edge of the response cycle, wiggling ignored inputs
  task automatic finish_req(input int rc);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
      if (cyc < rc) junk_req(1'($urandom_range(0, 1)));
    end while (cyc < rc && g < 20);
    i_req_valid = 1'b0;
  endtask

  task automatic run(input bit we, input bit [2:0] f3, input bit [31:0] a,
                     input bit [31:0] wd, output int c0);
    int rc;
    accept(we, f3, a, wd, c0, rc);
    if (c0 >= 0) finish_req(rc);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int rc;
    bit [11:0] lo;
    bit [2:0]  f3;
    for (int i = 0; i < 4096; i++) begin
      ram[i]    = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    junk_req(1'b0);
    exp_aset[1] = 1'b1;
    exp_addr[1] = 12'h000;
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Word store then load
    run(1'b1, 3'b010, 32'h0000_0010, 32'h8381_8283, c0);
    chk("sw_b0", 32'(ram[12'h010]), 32'h83);
    chk("sw_b1", 32'(ram[12'h011]), 32'h82);
    chk("sw_b2", 32'(ram[12'h012]), 32'h81);
    chk("sw_b3", 32'(ram[12'h013]), 32'h83);
    run(1'b0, 3'b010, 32'h0000_0010, 32'h0, c0);
    chk("lw_latency", 32'(last_resp_cyc - c0), 32'd5);
    chk("lw_rdata", last_rdata, 32'h8381_8283);

    // Byte sign handling
    run(1'b1, 3'b000, 32'h0000_0020, 32'hABCD_EF80, c0);
    chk("sb_latency", 32'(last_resp_cyc - c0), 32'd1);
    run(1'b0, 3'b000, 32'h0000_0020, 32'h0, c0);
    chk("lb_latency", 32'(last_resp_cyc - c0), 32'd2);
    chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
    run(1'b0, 3'b100, 32'h0000_0020, 32'h0, c0);
    chk("lbu_rdata", last_rdata, 32'h0000_0080);

    // Misaligned halfword
    run(1'b1, 3'b000, 32'h0000_0003, 32'h0000_0034, c0);
    run(1'b1, 3'b000, 32'h0000_0004, 32'h0000_0092, c0);
    run(1'b0, 3'b001, 32'h0000_0003, 32'h0, c0);
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    chk("lh_mis_latency", 32'(last_resp_cyc - c0), 32'd0);
    chk("lh_mis_err", 32'(last_err), 32'd1);
    chk("lh_mis_addr", 32'(o_mem_address), 32'h004);
`else
    chk("lh_mis_latency", 32'(last_resp_cyc - c0), 32'd3);
    chk("lh_mis_rdata", last_rdata, 32'hFFFF_9234);

    // Wrap-around word store and load
    run(1'b1, 3'b010, 32'h0000_0FFE, 32'hDDCC_BBAA, c0);
    chk("wrap_ffe", 32'(ram[12'hFFE]), 32'hAA);
    chk("wrap_fff", 32'(ram[12'hFFF]), 32'hBB);
    chk("wrap_000", 32'(ram[12'h000]), 32'hCC);
    chk("wrap_001", 32'(ram[12'h001]), 32'hDD);
    run(1'b0, 3'b010, 32'h0000_0FFE, 32'h0, c0);
    chk("wrap_lw", last_rdata, 32'hDDCC_BBAA);
`endif

    // Illegal funct3 on a store
    run(1'b1, 3'b100, 32'h0000_0050, 32'h1234_5678, c0);
    chk("ill_latency", 32'(last_resp_cyc - c0), 32'd0);
    chk("ill_err", 32'(last_err), 32'd1);

    // Reset in the middle of a word store
    accept(1'b1, 3'b010, 32'h0000_0040, 32'h1122_3344, c0, rc);
    if (c0 >= 0) begin
      @(posedge clk);
      #1 rst = 1'b1;
      for (int c = c0 + 2; c <= c0 + 6; c++) begin
        exp_busy[c] = 1'b0; exp_wren[c] = 1'b0; exp_data[c] = 8'h00;
        exp_rv[c] = 1'b0; exp_err[c] = 1'b0; exp_rdata[c] = 32'h0;
        exp_aset[c] = 1'b0;
      end
      exp_aset[c0+2] = 1'b1;
      exp_addr[c0+2] = 12'h000;
      shadow[12'h042] = 8'h42 ^ 8'h5A;
      shadow[12'h043] = 8'h43 ^ 8'h5A;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("rst_b0", 32'(ram[12'h040]), 32'h44);
      chk("rst_b1", 32'(ram[12'h041]), 32'h33);
      chk("rst_b2", 32'(ram[12'h042]), 32'h18);
      chk("rst_b3", 32'(ram[12'h043]), 32'h19);
      chk("rst_no_resp", 32'(last_resp_cyc < c0), 32'd1);
    end

    // Randomized traffic over a small window plus the wrap region
    for (int i = 0; i < 300; i++) begin
      lo = ($urandom_range(0, 3) == 0) ? 12'hFFC + 12'($urandom_range(0, 5))
                                       : 12'h100 + 12'($urandom_range(0, 31));
      f3 = ($urandom_range(0, 9) >= 8) ? 3'd2 : 3'($urandom_range(0, 7));
      run(1'($urandom_range(0, 1)), f3, ($urandom & 32'hFFFF_F000) | 32'(lo),
          $urandom, c0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv32i_lsu_byteseq.md
# rv32i_lsu_byteseq

Load/store sequencer that sits between the RV32I core's memory stage and the byte-wide 4 KB data RAM. It turns one 32-bit LB/LH/LW/LBU/LHU/SB/SH/SW request into 1, 2 or 4 consecutive byte accesses, little-endian. It drives the RAM's data, write-enable and address inputs and consumes its registered read output. On loads it reassembles the bytes and zero- or sign-extends them to 32 bits.

## Interface
- AWIDTH, 12: RAM address width; RAM holds 2**AWIDTH bytes.
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high when IDLE and reset low; the request is accepted on an edge where req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (size/sign).
- req_addr  in  32  byte address; only [AWIDTH-1:0] is used.
- req_wdata  in  32  store data; the low n bytes are used.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualified by resp_valid; illegal or misaligned request.
- resp_rdata  out  32  load result; 0 for stores and errors.
- mem_data  out  8  byte to RAM.
- mem_wren  out  1  RAM write enable.
- mem_address  out  AWIDTH  RAM byte address.
- mem_q  in  8  RAM read data, valid one cycle after the address is sampled.

## Operation
- States: IDLE, STORE, LOAD, RESP.
- Reset behaviour:
  - All registered outputs are 0: mem_data, mem_wren, mem_address, resp_valid, resp_err, resp_rdata.
  - State becomes IDLE.
  - req_ready is 0 while reset is high.
- Size decode:
  - funct3 000 → n=1, 001 → n=2, 010 → n=4.
  - Loads additionally accept 100 (LBU) and 101 (LHU); these are unsigned.
  - Any other code is illegal.
- Illegal request: the block goes to RESP with resp_err=1 and makes no memory access.
- Byte k (k = 0..n-1) is at address (req_addr + k) mod 2**AWIDTH. The address wraps from 2**AWIDTH-1 to 0.
- STORE:
  - Issue cycle k drives mem_wren=1, mem_address=base+k, mem_data=req_wdata[8k+7:8k].
  - After byte n-1 the block goes to RESP.
- LOAD:
  - Issue cycle k drives mem_wren=0, mem_address=base+k.
  - mem_q is captured into byte lane k one cycle later.
  - Issue and capture overlap (pipelined).
  - The final capture writes resp_rdata directly.
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW takes all 32 bits.
- RESP:
  - resp_valid=1 for one cycle; state returns to IDLE at the same edge resp_valid is registered.
  - req_ready is high in the resp_valid cycle, so back-to-back requests are allowed.
- Outside issue cycles: mem_wren=0, mem_data=0, mem_address holds its last value.
- Reset during STORE/LOAD:
  - The transaction is aborted; there is no resp_valid.
  - mem_wren is 0 from the next cycle.
  - Bytes already written stay written.

## Timing
- Acceptance edge: E0. Edge Ej is j edges later.
- Memory outputs are registered: byte k is presented during the cycle after Ek and sampled by the RAM at Ek+1.
- Store: byte k is written at Ek+1. resp_valid is high in the cycle after En. Latency is n cycles (SB 1, SH 2, SW 4).
- Load: mem_q for byte k is captured at Ek+2. resp_valid and resp_rdata are registered at En+1. Latency is n+1 cycles (LB 2, LH 3, LW 5).
- Error: resp_valid and resp_err are high in the cycle after E0.
- Throughput: a new request can be accepted on the edge that ends the resp_valid cycle.
- req_* inputs are sampled only at acceptance and latched; they are don't-care afterwards.

## Configuration
- RV32I_LSU_MISALIGN_TRAP_EN defined:
  - An LH/LHU/SH with req_addr[0]=1, or an LW/SW with req_addr[1:0]≠0, is an error.
  - Error timing and behaviour are the same as for an illegal funct3.
  - No memory access is made.
- RV32I_LSU_MISALIGN_TRAP_EN undefined:
  - Misaligned requests are performed bytewise with address wrap-around.
  - resp_err is set only for illegal funct3.

## Test plan
- Store then load a word:
  - Stimulus: SW 0x8381_8283 to 0x010, then LW 0x010.
  - Required: 4 writes at 0x010..0x013, bytes 83,82,81,83.
  - Required: load resp_valid 5 cycles after acceptance with rdata 0x8381_8283.
- Byte sign handling:
  - Stimulus: SB 0x80 to 0x020, then LB 0x020, then LBU 0x020.
  - Required: LB returns 0xFFFF_FF80; LBU returns 0x0000_0080.
- Misaligned halfword:
  - Stimulus: LH at 0x003 holding bytes 0x34 (0x003), 0x92 (0x004).
  - Macro defined: resp_err=1 one cycle after acceptance, mem_address unchanged.
  - Macro undefined: rdata 0xFFFF_9234.
- Wrap-around (macro undefined):
  - Stimulus: SW 0xDDCC_BBAA at 0xFFE.
  - Required: writes AA@FFE, BB@FFF, CC@000, DD@001; LW 0xFFE returns 0xDDCC_BBAA.
- Reset mid-store:
  - Stimulus: SW 0x1122_3344 at 0x040; assert reset for 1 cycle after the second byte is written.
  - Required: no resp_valid; mem_wren is 0 the cycle after reset.
  - Required: 0x040=44, 0x041=33; 0x042/0x043 unchanged.
- Illegal funct3:
  - Stimulus: store with funct3=100.
  - Required: resp_valid=resp_err=1 after 1 cycle; mem_wren never asserted; req_ready high in the resp cycle.
